camera_emulator: RTL and testbench



---
 rtl/camera_emulator_pkg.sv | 30 +++
 rtl/camera_emulator_sclk_activity_mon.sv | 45 ++++
 rtl/camera_emulator.sv | 131 +++++++++++++
 tb/tb_camera_emulator.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/camera_emulator_pkg.sv
// Shared types and default timing for the camera-sensor emulator.
// Define D_SIM to shrink the INT delay to something a simulation can wait for.
package camera_emu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      WAIT  = 2'd2
   } state_e;

   localparam bit LK_ALTERNATE = 1'b0;
   localparam bit LK_EVERY     = 1'b1;

   localparam int DEF_DETECT_TIMEOUT = 8;
`ifdef D_SIM
   localparam int DEF_INT_DELAY      = 12;
`else
   localparam int DEF_INT_DELAY      = 12004;
`endif
   localparam int DEF_CNT_W          = 32;
   localparam int DEF_FRAME_W        = 8;

   // Host-facing level outputs, registered together.
   typedef struct packed {
      logic intr;
      logic lookup;
      logic busy;
   } emu_out_t;

endpackage

// File: rtl/camera_emulator_sclk_activity_mon.sv
// SCLK synchroniser, both-polarity edge detector and burst idle timer.
// active stays high while the burst continues into the next CLK cycle.
module sclk_activity_mon #(
   parameter int DETECT_TIMEOUT = 8
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic SCLK,
   input  logic EN,
   output logic edge_pulse,
   output logic active
);

   localparam int             TW     = $clog2(DETECT_TIMEOUT + 1);
   localparam logic [TW-1:0]  T_LOAD = TW'(DETECT_TIMEOUT);
   localparam logic [TW-1:0]  T_ONE  = TW'(1);

   logic          sync_q1, sync_q2, sync_prev;
   logic [TW-1:0] timer_q;

   // The synchroniser keeps tracking while disabled so re-enabling never
   // produces a stale edge.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync_q1   <= 1'b0;
         sync_q2   <= 1'b0;
         sync_prev <= 1'b0;
         timer_q   <= '0;
      end else begin
         sync_q1   <= SCLK;
         sync_q2   <= sync_q1;
         sync_prev <= sync_q2;
         if (EN) begin
            if (edge_pulse)
               timer_q <= T_LOAD;
            else if (timer_q != '0)
               timer_q <= timer_q - T_ONE;
         end
      end
   end

   assign edge_pulse = EN && (sync_q2 != sync_prev);
   assign active     = edge_pulse || (timer_q > T_ONE);

endmodule

// File: rtl/camera_emulator.sv
// Camera-sensor emulator: SCLK bursts -> LOOKUP, delayed INT, frame count
// and sticky overrun when a new burst interrupts a pending INT delay.
module camera_emulator
   import camera_emu_pkg::*;
#(
   parameter int DETECT_TIMEOUT = DEF_DETECT_TIMEOUT,
   parameter int INT_DELAY      = DEF_INT_DELAY,
   parameter int CNT_W          = DEF_CNT_W,
   parameter int FRAME_W        = DEF_FRAME_W,
   parameter bit LOOKUP_MODE    = LK_ALTERNATE
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               SCLK,
   input  logic               EN,
   input  logic               OVR_CLR,
   output logic               INT,
   output logic               LOOKUP,
   output logic               BUSY,
   output logic               OVERRUN,
   output logic [FRAME_W-1:0] FRAME_CNT
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INT_DELAY - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_e             state_q, state_d;
   emu_out_t           out_q, out_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [FRAME_W-1:0] frame_q, frame_d;
   logic               phase_q, phase_d;
   logic               ovr_q, ovr_d;
   logic               start, ovr_set;
   logic               edge_pulse, active;

   sclk_activity_mon #(
      .DETECT_TIMEOUT (DETECT_TIMEOUT)
   ) u_mon (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .SCLK       (SCLK),
      .EN         (EN),
      .edge_pulse (edge_pulse),
      .active     (active)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         out_q   <= '0;
         cnt_q   <= '0;
         frame_q <= '0;
         phase_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         cnt_q   <= cnt_d;
         frame_q <= frame_d;
         phase_q <= phase_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      cnt_d   = cnt_q;
      frame_d = frame_q;
      phase_d = phase_q;
      start   = 1'b0;
      ovr_set = 1'b0;

      if (!EN) begin
         state_d = IDLE;
         out_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               start = edge_pulse;
            end
            BURST: begin
               if (!active) begin
                  state_d     = WAIT;
                  out_d.busy  = 1'b0;
                  out_d.lookup = (LOOKUP_MODE == LK_EVERY) ? 1'b1 : phase_q;
                  cnt_d       = '0;
               end
            end
            WAIT: begin
               if (edge_pulse) begin
                  // New burst before INT fired: drop the pending frame.
                  ovr_set = 1'b1;
                  start   = 1'b1;
               end else if (cnt_q == CNT_LAST) begin
                  state_d    = IDLE;
                  out_d.intr = 1'b1;
                  frame_d    = frame_q + 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: state_d = IDLE;
         endcase

         if (start) begin
            state_d      = BURST;
            out_d.intr   = 1'b0;
            out_d.lookup = 1'b0;
            out_d.busy   = 1'b1;
            if (LOOKUP_MODE == LK_ALTERNATE)
               phase_d = ~phase_q;
         end
      end

      // Set beats clear; both are ignored while disabled.
      if (ovr_set)
         ovr_d = 1'b1;
      else if (EN && OVR_CLR)
         ovr_d = 1'b0;
      else
         ovr_d = ovr_q;
   end

   assign INT       = out_q.intr;
   assign LOOKUP    = out_q.lookup;
   assign BUSY      = out_q.busy;
   assign OVERRUN   = ovr_q;
   assign FRAME_CNT = frame_q;

endmodule

// File: tb/tb_camera_emulator.sv
// Bench for camera_emulator: three instances (alternate, every-burst, 2-bit
// frame counter) share random SCLK stimulus and are checked against a frame model.
module tb_camera_emulator;
   import camera_emu_pkg::*;

   localparam int DT = 8;
   localparam int ID = 12;

   logic       CLK = 1'b0, RST_N = 1'b0, SCLK = 1'b0, EN = 1'b0, OVR_CLR = 1'b0;
   logic [2:0] intr, lookup, busy, ovr;
   logic [7:0] fc0, fc1;
   logic [1:0] fc2;

   int checks = 0, errors = 0;
   int frames = 0, starts = 0;
   bit ovr_exp = 1'b0;

   always #5 CLK = ~CLK;

   camera_emulator #(.DETECT_TIMEOUT(DT), .INT_DELAY(ID), .CNT_W(16), .FRAME_W(8),
                     .LOOKUP_MODE(LK_ALTERNATE)) u_alt (
      .CLK(CLK), .RST_N(RST_N), .SCLK(SCLK), .EN(EN), .OVR_CLR(OVR_CLR),
      .INT(intr[0]), .LOOKUP(lookup[0]), .BUSY(busy[0]), .OVERRUN(ovr[0]), .FRAME_CNT(fc0));

   camera_emulator #(.DETECT_TIMEOUT(DT), .INT_DELAY(ID), .CNT_W(16), .FRAME_W(8),
                     .LOOKUP_MODE(LK_EVERY)) u_every (
      .CLK(CLK), .RST_N(RST_N), .SCLK(SCLK), .EN(EN), .OVR_CLR(OVR_CLR),
      .INT(intr[1]), .LOOKUP(lookup[1]), .BUSY(busy[1]), .OVERRUN(ovr[1]), .FRAME_CNT(fc1));

   camera_emulator #(.DETECT_TIMEOUT(DT), .INT_DELAY(ID), .CNT_W(16), .FRAME_W(2),
                     .LOOKUP_MODE(LK_ALTERNATE)) u_fw2 (
      .CLK(CLK), .RST_N(RST_N), .SCLK(SCLK), .EN(EN), .OVR_CLR(OVR_CLR),
      .INT(intr[2]), .LOOKUP(lookup[2]), .BUSY(busy[2]), .OVERRUN(ovr[2]), .FRAME_CNT(fc2));

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Odd-numbered bursts raise LOOKUP in alternate mode; every-burst mode always does.
   function automatic logic [2:0] exp_lookup();
      logic a;
      a = (starts % 2) == 1;
      return {a, 1'b1, a};
   endfunction

   task automatic run_burst(input int n, input bit clr, output int since);
      int w;
      SCLK = ~SCLK;
      starts++;
      if (clr) OVR_CLR = 1'b1;
      w = 0;
      while (busy[0] !== 1'b1 && w < 6) begin tick(); w++; end
      OVR_CLR = 1'b0;
      checks++;
      if (busy !== 3'b111 || intr !== 3'b000 || lookup !== 3'b000) begin
         errors++;
         $display("FAIL burst_start: busy=%b int=%b lookup=%b, required busy=111 int=000 lookup=000",
                  busy, intr, lookup);
      end
      since = w;
      for (int i = 1; i < n; i++) begin
         SCLK  = ~SCLK;
         since = 0;
         repeat ($urandom_range(1, 3)) begin tick(); since++; end
      end
   endtask

   task automatic end_burst(input int since0);
      int since, n;
      since = since0;
      while (busy[0] === 1'b1 && since < DT + 20) begin tick(); since++; end
      checks++;
      if (since < DT + 2 || since > DT + 4 || busy !== 3'b000) begin
         errors++;
         $display("FAIL busy_fall: %0d cycles after last SCLK change busy=%b, required %0d..%0d cycles busy=000",
                  since, busy, DT + 2, DT + 4);
      end
      checks++;
      if (lookup !== exp_lookup()) begin
         errors++;
         $display("FAIL lookup: got %b, required %b (burst %0d)", lookup, exp_lookup(), starts);
      end
      n = 0;
      while (intr[0] !== 1'b1 && n < ID + 20) begin tick(); n++; end
      frames++;
      checks++;
      if (n != ID || intr !== 3'b111) begin
         errors++;
         $display("FAIL int_delay: int=%b after %0d cycles, required 111 after %0d", intr, n, ID);
      end
      checks++;
      if (fc0 !== 8'(frames) || fc1 !== 8'(frames) || fc2 !== 2'(frames)) begin
         errors++;
         $display("FAIL frame_cnt: got %0d/%0d/%0d, required %0d/%0d/%0d",
                  fc0, fc1, fc2, 8'(frames), 8'(frames), 2'(frames));
      end
      checks++;
      if (ovr !== {3{ovr_exp}}) begin
         errors++;
         $display("FAIL overrun_hold: got %b, required %b", ovr, {3{ovr_exp}});
      end
   endtask

   task automatic wait_busy_fall();
      int w;
      w = 0;
      while (busy[0] === 1'b1 && w < DT + 20) begin tick(); w++; end
   endtask

   task automatic test_reset();
      bit bad;
      RST_N = 1'b0;
      EN    = 1'b1;
      bad   = 1'b0;
      repeat (6) begin
         SCLK = ~SCLK;
         tick();
         if ({intr, lookup, busy, ovr} !== '0 || fc0 !== 0 || fc1 !== 0 || fc2 !== 0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL reset_hold: outputs nonzero during reset, required all 0");
      end
      SCLK = 1'b0;
      tick();
      RST_N = 1'b1;
      bad   = 1'b0;
      repeat (100) begin
         tick();
         if ({intr, lookup, busy, ovr} !== '0 || fc0 !== 0 || fc1 !== 0 || fc2 !== 0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL reset_idle: outputs int=%b lookup=%b busy=%b ovr=%b fc=%0d, required all 0",
                  intr, lookup, busy, ovr, fc0);
      end
   endtask

   task automatic test_frames();
      int s;
      for (int k = 0; k < 5; k++) begin
         run_burst($urandom_range(2, 20), 1'b0, s);
         end_burst(s);
         repeat ($urandom_range(1, 8)) tick();
      end
   endtask

   task automatic test_overrun();
      int s;
      run_burst($urandom_range(2, 10), 1'b0, s);
      wait_busy_fall();
      repeat (3) tick();
      run_burst($urandom_range(2, 10), 1'b0, s);
      ovr_exp = 1'b1;
      checks++;
      if (ovr !== 3'b111 || intr !== 3'b000 || fc0 !== 8'(frames) || fc2 !== 2'(frames)) begin
         errors++;
         $display("FAIL overrun_set: ovr=%b int=%b fc=%0d, required ovr=111 int=000 fc=%0d",
                  ovr, intr, fc0, 8'(frames));
      end
      end_burst(s);

      OVR_CLR = 1'b1;
      tick();
      OVR_CLR = 1'b0;
      ovr_exp = 1'b0;
      checks++;
      if (ovr !== 3'b000) begin
         errors++;
         $display("FAIL overrun_clear: got %b, required 000", ovr);
      end

      run_burst($urandom_range(2, 10), 1'b0, s);
      wait_busy_fall();
      repeat (2) tick();
      run_burst($urandom_range(2, 10), 1'b1, s);
      ovr_exp = 1'b1;
      checks++;
      if (ovr !== 3'b111) begin
         errors++;
         $display("FAIL overrun_set_wins: got %b, required 111", ovr);
      end
      end_burst(s);
   endtask

   task automatic test_enable();
      int s;
      bit bad;
      run_burst(6, 1'b0, s);
      EN = 1'b0;
      tick();
      checks++;
      if (busy !== 3'b000 || intr !== 3'b000 || lookup !== 3'b000) begin
         errors++;
         $display("FAIL en_drop: busy=%b int=%b lookup=%b, required all 000", busy, intr, lookup);
      end
      bad = 1'b0;
      repeat (10) begin
         SCLK = ~SCLK;
         tick();
         tick();
         if (busy !== 3'b000 || intr !== 3'b000) bad = 1'b1;
      end
      repeat (5) tick();
      checks++;
      if (bad || fc0 !== 8'(frames) || ovr !== {3{ovr_exp}}) begin
         errors++;
         $display("FAIL en_low_ignore: activity=%0d fc=%0d ovr=%b, required 0 fc=%0d ovr=%b",
                  bad, fc0, ovr, 8'(frames), {3{ovr_exp}});
      end
      EN = 1'b1;
      repeat (5) tick();
      checks++;
      if (busy !== 3'b000 || intr !== 3'b000) begin
         errors++;
         $display("FAIL en_resume_idle: busy=%b int=%b, required 000 000", busy, intr);
      end
      run_burst($urandom_range(2, 20), 1'b0, s);
      end_burst(s);
   endtask

   task automatic test_reset_mid_wait();
      int s;
      bit bad;
      run_burst($urandom_range(2, 10), 1'b0, s);
      wait_busy_fall();
      repeat (4) tick();
      #2 RST_N = 1'b0;
      #1;
      checks++;
      if ({intr, lookup, busy, ovr} !== '0 || fc0 !== 0 || fc1 !== 0 || fc2 !== 0) begin
         errors++;
         $display("FAIL reset_async: int=%b lookup=%b busy=%b ovr=%b fc=%0d, required all 0",
                  intr, lookup, busy, ovr, fc0);
      end
      SCLK    = 1'b0;
      frames  = 0;
      starts  = 0;
      ovr_exp = 1'b0;
      tick();
      tick();
      RST_N = 1'b1;
      bad   = 1'b0;
      repeat (ID + 10) begin
         tick();
         if (intr !== 3'b000 || busy !== 3'b000) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL reset_no_int: int or busy rose after reset in delay, required none");
      end
      run_burst($urandom_range(2, 20), 1'b0, s);
      end_burst(s);
   endtask

   initial begin
      test_reset();
      test_frames();
      test_overrun();
      test_enable();
      test_reset_mid_wait();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
